// File: rtl/pcie_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_fifo_pkg
// Purpose  : Shared constants and helpers for the lane-packing FIFO.
//            Holds the default parameter values used by the interface,
//            the lane packer and the top level, plus the width helper
//            for lane counts (0..RATIO needs clog2(RATIO)+1 bits).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pcie_fifo_pkg;

  localparam int DEF_WR_DATA_WIDTH    = 16;
  localparam int DEF_RATIO            = 8;
  localparam int DEF_RD_DEPTH_WIDTH   = 10;
  localparam int DEF_ALMOST_FULL_NUM  = 8128;
  localparam int DEF_ALMOST_EMPTY_NUM = 4;

  // Width of a field that must hold any lane count from 0 up to and
  // including ratio (a fully packed word reports ratio lanes).
  function automatic int lane_cnt_width(input int ratio);
    return $clog2(ratio) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcie_pack_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : pcie_pack_fifo_if
// Purpose  : Write/read bundle of the lane-packing FIFO.
//            master : the client (drives wr_*/rd_en, observes status/data)
//            slave  : the FIFO itself
// Signals  : wr_en, wr_data, wr_flush, wr_full, almost_full, wr_water_level,
//            rd_en, rd_data, rd_lanes, rd_empty, almost_empty, rd_water_level
// Revision : 1.0 - initial release
// ============================================================================
interface pcie_pack_fifo_if
  import pcie_fifo_pkg::*;
#(
  parameter int WR_DATA_WIDTH  = DEF_WR_DATA_WIDTH,
  parameter int RATIO          = DEF_RATIO,
  parameter int RD_DEPTH_WIDTH = DEF_RD_DEPTH_WIDTH
) ();

  localparam int LW = lane_cnt_width(RATIO);

  // write side
  logic                              wr_en;
  logic [WR_DATA_WIDTH-1:0]          wr_data;
  logic                              wr_flush;
  logic                              wr_full;
  logic                              almost_full;
  logic [RD_DEPTH_WIDTH+LW-1:0]      wr_water_level;

  // read side
  logic                              rd_en;
  logic [WR_DATA_WIDTH*RATIO-1:0]    rd_data;
  logic [LW-1:0]                     rd_lanes;
  logic                              rd_empty;
  logic                              almost_empty;
  logic [RD_DEPTH_WIDTH:0]           rd_water_level;

  modport master (
    output wr_en, wr_data, wr_flush, rd_en,
    input  wr_full, almost_full, wr_water_level,
    input  rd_data, rd_lanes, rd_empty, almost_empty, rd_water_level
  );

  modport slave (
    input  wr_en, wr_data, wr_flush, rd_en,
    output wr_full, almost_full, wr_water_level,
    output rd_data, rd_lanes, rd_empty, almost_empty, rd_water_level
  );

endinterface
`default_nettype wire

// File: rtl/pcie_fifo_lane_packer.sv
`default_nettype none
// ============================================================================
// Module   : pcie_fifo_lane_packer
// Purpose  : Accumulates WR_DATA_WIDTH lanes into a RATIO-lane word.
//            Lane k of a word lands at bits [k*W +: W]. A word is committed
//            when its last lane is accepted or when a flush arrives with at
//            least one lane pending (including a lane accepted in the same
//            cycle). Unfilled lanes of a flushed word are zero.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            accept          - take lane_data this cycle (already gated)
//            flush           - commit the partial word (already gated)
//            lane_data       - incoming lane
//            commit          - a word is committed at this edge
//            commit_data     - word being committed
//            commit_lanes    - valid lanes in the committed word (1..RATIO)
//            count_next      - lanes held by the packer after this edge
// Revision : 1.0 - initial release
// ============================================================================
module pcie_fifo_lane_packer
  import pcie_fifo_pkg::*;
#(
  parameter int WR_DATA_WIDTH = DEF_WR_DATA_WIDTH,
  parameter int RATIO         = DEF_RATIO
) (
  input  wire logic                                clk,
  input  wire logic                                rst,
  input  wire logic                                accept,
  input  wire logic                                flush,
  input  wire logic [WR_DATA_WIDTH-1:0]            lane_data,
  output logic                                     commit,
  output logic [WR_DATA_WIDTH*RATIO-1:0]           commit_data,
  output logic [lane_cnt_width(RATIO)-1:0]         commit_lanes,
  output logic [lane_cnt_width(RATIO)-1:0]         count_next
);

  localparam int              LW           = lane_cnt_width(RATIO);
  localparam int              WORD_W       = WR_DATA_WIDTH * RATIO;
  localparam logic [LW-1:0]   C_FULL_COUNT = LW'(RATIO);

  logic [WORD_W-1:0] r_data;
  logic [LW-1:0]     r_count;
  logic [LW-1:0]     w_count_inc;
  wire  [WORD_W-1:0] w_merged;

  // Drop the new lane into the slot selected by the current count; every
  // other slot keeps what is already held (zero if not yet written).
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    assign w_merged[k*WR_DATA_WIDTH +: WR_DATA_WIDTH] =
      (accept && (r_count == LW'(k))) ? lane_data
                                      : r_data[k*WR_DATA_WIDTH +: WR_DATA_WIDTH];
  end

  assign w_count_inc  = r_count + LW'(accept);

  // A same-cycle lane that completes the word and a flush still produce
  // exactly one commit: both terms describe the same word.
  assign commit       = (accept && (w_count_inc == C_FULL_COUNT)) ||
                        (flush  && (w_count_inc != '0));
  assign commit_data  = w_merged;
  assign commit_lanes = w_count_inc;
  assign count_next   = commit ? '0 : w_count_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_count <= '0;
    end else if (commit) begin
      // clearing keeps unfilled lanes of the next flushed word at zero
      r_data  <= '0;
      r_count <= '0;
    end else if (accept) begin
      r_data  <= w_merged;
      r_count <= w_count_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pcie_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pcie_pack_fifo
// Purpose  : Lane-packing FIFO. Narrow lanes are packed into RATIO-lane
//            words, stored in a 2^RD_DEPTH_WIDTH-word buffer and presented
//            first-word-fall-through from a registered head. Every status
//            output is registered from the next-state counters.
//            RATIO must be 2, 4, 8 or 16.
// Ports    : clk, rst  - clock, synchronous active-high reset
//            bus       - pcie_pack_fifo_if.slave:
//                        wr_en/wr_data/wr_flush in, wr_full/almost_full/
//                        wr_water_level out, rd_en in, rd_data/rd_lanes/
//                        rd_empty/almost_empty/rd_water_level out
// Revision : 1.0 - initial release
// ============================================================================
module pcie_pack_fifo
  import pcie_fifo_pkg::*;
#(
  parameter int WR_DATA_WIDTH    = DEF_WR_DATA_WIDTH,
  parameter int RATIO            = DEF_RATIO,
  parameter int RD_DEPTH_WIDTH   = DEF_RD_DEPTH_WIDTH,
  parameter int ALMOST_FULL_NUM  = DEF_ALMOST_FULL_NUM,
  parameter int ALMOST_EMPTY_NUM = DEF_ALMOST_EMPTY_NUM
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pcie_pack_fifo_if.slave  bus
);

  localparam int LW     = lane_cnt_width(RATIO);
  localparam int WORD_W = WR_DATA_WIDTH * RATIO;
  localparam int DEPTH  = 1 << RD_DEPTH_WIDTH;
  localparam int LVW    = RD_DEPTH_WIDTH + 1;   // stored-word count width
  localparam int WLW    = RD_DEPTH_WIDTH + LW;  // lane water level width

  // input qualification
  logic                      w_accept;
  logic                      w_flush;
  logic                      w_pop;

  // packer
  logic                      w_commit;
  logic [WORD_W-1:0]         w_commit_data;
  logic [LW-1:0]             w_commit_lanes;
  logic [LW-1:0]             w_pack_count_next;

  // storage
  logic [WORD_W-1:0]         r_mem_data  [DEPTH];
  logic [LW-1:0]             r_mem_lanes [DEPTH];
  logic [RD_DEPTH_WIDTH-1:0] r_wr_ptr;
  logic [RD_DEPTH_WIDTH-1:0] r_rd_ptr;
  logic [RD_DEPTH_WIDTH-1:0] w_rd_ptr_inc;

  // counters and registered status
  logic [LVW-1:0]            r_level;
  logic [LVW-1:0]            w_level_next;
  logic [WLW-1:0]            r_stored_lanes;
  logic [WLW-1:0]            w_stored_next;
  logic [WLW-1:0]            w_wl_next;
  logic [WLW-1:0]            r_wr_water_level;
  logic                      r_rd_empty;
  logic                      r_wr_full;
  logic                      r_almost_full;
  logic                      r_almost_empty;

  // FWFT head
  logic [WORD_W-1:0]         r_head_data;
  logic [LW-1:0]             r_head_lanes;
  logic                      w_head_from_ram;
  logic                      w_head_from_commit;

  // Inputs are ignored entirely while reset is asserted.
  assign w_accept = bus.wr_en    && !r_wr_full  && !rst;
  assign w_flush  = bus.wr_flush && !r_wr_full  && !rst;
  assign w_pop    = bus.rd_en    && !r_rd_empty && !rst;

  pcie_fifo_lane_packer #(
    .WR_DATA_WIDTH (WR_DATA_WIDTH),
    .RATIO         (RATIO)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .accept       (w_accept),
    .flush        (w_flush),
    .lane_data    (bus.wr_data),
    .commit       (w_commit),
    .commit_data  (w_commit_data),
    .commit_lanes (w_commit_lanes),
    .count_next   (w_pack_count_next)
  );

  assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

  always_comb begin
    w_level_next  = r_level + LVW'(w_commit) - LVW'(w_pop);

    w_stored_next = r_stored_lanes;
    if (w_commit) begin
      w_stored_next = w_stored_next + WLW'(w_commit_lanes);
    end
    if (w_pop) begin
      w_stored_next = w_stored_next - WLW'(r_head_lanes);
    end
    w_wl_next = w_stored_next + WLW'(w_pack_count_next);

    // The head refills from the buffer when a word behind it was already
    // stored; otherwise a word committed at this edge goes straight to the
    // head (empty buffer, or a pop of the only word), so one-word steady
    // state streams without a bubble.
    w_head_from_ram    = w_pop && (r_level > LVW'(1));
    w_head_from_commit = w_commit &&
                         ((r_level == '0) || (w_pop && (r_level == LVW'(1))));
  end

  // Storage array: no reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem_data[r_wr_ptr]  <= w_commit_data;
      r_mem_lanes[r_wr_ptr] <= w_commit_lanes;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_level          <= '0;
      r_stored_lanes   <= '0;
      r_wr_water_level <= '0;
      r_rd_empty       <= 1'b1;
      r_wr_full        <= 1'b0;
      r_almost_full    <= 1'b0;
      r_almost_empty   <= 1'b1;
      r_head_data      <= '0;
      r_head_lanes     <= '0;
    end else begin
      if (w_commit) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end

      r_level          <= w_level_next;
      r_stored_lanes   <= w_stored_next;
      r_wr_water_level <= w_wl_next;
      r_rd_empty       <= (w_level_next == '0);
      r_wr_full        <= (w_level_next == LVW'(DEPTH));
      r_almost_empty   <= (32'(w_level_next) <= 32'(ALMOST_EMPTY_NUM));
      r_almost_full    <= (32'(w_wl_next)    >= 32'(ALMOST_FULL_NUM));

      if (w_head_from_ram) begin
        r_head_data  <= r_mem_data[w_rd_ptr_inc];
        r_head_lanes <= r_mem_lanes[w_rd_ptr_inc];
      end else if (w_head_from_commit) begin
        r_head_data  <= w_commit_data;
        r_head_lanes <= w_commit_lanes;
      end
    end
  end

  assign bus.wr_full        = r_wr_full;
  assign bus.almost_full    = r_almost_full;
  assign bus.wr_water_level = r_wr_water_level;
  assign bus.rd_data        = r_head_data;
  assign bus.rd_lanes       = r_head_lanes;
  assign bus.rd_empty       = r_rd_empty;
  assign bus.almost_empty   = r_almost_empty;
  assign bus.rd_water_level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_pcie_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_pack_fifo
// Purpose  : Self-checking bench for pcie_pack_fifo (W=16, R=8, D=4,
//            almost-full 120 lanes, almost-empty 1 word). A queue-based
//            reference model predicts flags and levels after every edge;
//            committed words go to a scoreboard that a negedge monitor
//            drains whenever the DUT pops a word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_pack_fifo;

  localparam int W     = 16;
  localparam int R     = 8;
  localparam int D     = 4;
  localparam int AFN   = 120;
  localparam int AEN   = 1;
  localparam int DEPTH = 16;

  typedef struct {
    logic [W*R-1:0] data;
    int             lanes;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pcie_pack_fifo_if #(.WR_DATA_WIDTH(W), .RATIO(R), .RD_DEPTH_WIDTH(D)) bus ();

  pcie_pack_fifo #(
    .WR_DATA_WIDTH    (W),
    .RATIO            (R),
    .RD_DEPTH_WIDTH   (D),
    .ALMOST_FULL_NUM  (AFN),
    .ALMOST_EMPTY_NUM (AEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  word_t          m_fifo[$];     // model of stored words
  word_t          sb[$];         // expected words, drained by the monitor
  logic [W-1:0]   m_partial[$];  // model of lanes waiting in the packer
  int total = 0;
  int bad   = 0;

  task automatic check_i(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_w(input string name, input logic [W*R-1:0] act,
                         input logic [W*R-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h req=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural rules: lanes pile up; 8 lanes or a flush with lanes pending
  // make a word; nothing is written while 16 words are held.
  task automatic model_edge(input bit r, input bit we, input logic [W-1:0] wd,
                            input bit fl, input bit re);
    bit    full;
    bit    popping;
    word_t w;
    if (r) begin
      m_fifo.delete();
      sb.delete();
      m_partial.delete();
      return;
    end
    full    = (m_fifo.size() == DEPTH);
    popping = re && (m_fifo.size() > 0);
    if (!full) begin
      if (we) m_partial.push_back(wd);
      if ((m_partial.size() == R) || (fl && (m_partial.size() > 0))) begin
        w.data = '0;
        foreach (m_partial[k]) w.data[k*W +: W] = m_partial[k];
        w.lanes = m_partial.size();
        m_fifo.push_back(w);
        sb.push_back(w);
        m_partial.delete();
      end
    end
    if (popping) void'(m_fifo.pop_front());
  endtask

  task automatic check_flags();
    int lanes_sum;
    lanes_sum = m_partial.size();
    foreach (m_fifo[i]) lanes_sum += m_fifo[i].lanes;
    check_i("rd_empty",       int'(bus.rd_empty),       int'(m_fifo.size() == 0));
    check_i("wr_full",        int'(bus.wr_full),        int'(m_fifo.size() == DEPTH));
    check_i("rd_water_level", int'(bus.rd_water_level), m_fifo.size());
    check_i("wr_water_level", int'(bus.wr_water_level), lanes_sum);
    check_i("almost_full",    int'(bus.almost_full),    int'(lanes_sum >= AFN));
    check_i("almost_empty",   int'(bus.almost_empty),   int'(m_fifo.size() <= AEN));
    if (m_fifo.size() > 0) begin
      check_w("head_data",  bus.rd_data,        m_fifo[0].data);
      check_i("head_lanes", int'(bus.rd_lanes), m_fifo[0].lanes);
    end
  endtask

  // One clock: drive, predict, let the edge happen, compare just after it.
  task automatic cycle(input bit r, input bit we, input logic [W-1:0] wd,
                       input bit fl, input bit re);
    rst          = r;
    bus.wr_en    = we;
    bus.wr_data  = wd;
    bus.wr_flush = fl;
    bus.rd_en    = re;
    model_edge(r, we, wd, fl, re);
    @(posedge clk);
    #1;
    check_flags();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 2*DEPTH + 4 && m_fifo.size() > 0; i++)
      cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_i("drain_done", m_fifo.size(), 0);
  endtask

  // Monitor: whenever the DUT will pop at the coming edge, its head word
  // must be the oldest word still expected.
  always @(negedge clk) begin : mon
    word_t e;
    if (!rst && bus.rd_en && !bus.rd_empty) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected act=rd_empty_0 req=no_word t=%0t", $time);
      end else begin
        e = sb.pop_front();
        check_w("pop_data",  bus.rd_data,        e.data);
        check_i("pop_lanes", int'(bus.rd_lanes), e.lanes);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [W*R-1:0] exp_word;

    // reset state
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_w("rst_rd_data", bus.rd_data, '0);
    check_i("rst_rd_lanes", int'(bus.rd_lanes), 0);
    idle();

    // eight lanes make one full word
    for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b1, W'(i), 1'b0, 1'b0);
    exp_word = 128'h0008_0007_0006_0005_0004_0003_0002_0001;
    check_i("full_word_rd_empty", int'(bus.rd_empty), 0);
    check_i("full_word_lanes", int'(bus.rd_lanes), 8);
    check_w("full_word_data", bus.rd_data, exp_word);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // three lanes then flush
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, W'(16'h00a1 + i), 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_i("flush3_lanes", int'(bus.rd_lanes), 3);
    check_w("flush3_upper_zero", bus.rd_data >> (3*W), '0);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_i("flush3_wl_after_pop", int'(bus.wr_water_level), 0);
    // flush with nothing pending is ignored
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_i("flush_empty_ignored", int'(bus.rd_water_level), 0);

    // seven lanes, then lane + flush in the same cycle: one 8-lane word
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, W'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 1'b1, W'($urandom), 1'b1, 1'b0);
    check_i("wr_flush_same_words", int'(bus.rd_water_level), 1);
    check_i("wr_flush_same_lanes", int'(bus.rd_lanes), 8);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // fill to full, drop extras, pop once, refill
    for (int i = 0; i < 128; i++) cycle(1'b0, 1'b1, W'($urandom), 1'b0, 1'b0);
    check_i("fill_wr_full", int'(bus.wr_full), 1);
    check_i("fill_almost_full", int'(bus.almost_full), 1);
    cycle(1'b0, 1'b1, 16'hbeef, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_i("dropped_wl", int'(bus.wr_water_level), 128);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check_i("pop_clears_full", int'(bus.wr_full), 0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, W'($urandom), 1'b0, 1'b0);
    check_i("refill_full", int'(bus.wr_full), 1);
    drain();

    // one-word steady state across pointer wrap
    cycle(1'b0, 1'b1, W'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, W'($urandom), 1'b1, 1'b1);
    check_i("steady_level", int'(bus.rd_water_level), 1);
    drain();

    // random traffic: write-heavy then read-heavy
    for (int i = 0; i < 800; i++) begin
      cycle(1'b0,
            ($urandom_range(0, 9) < 7),
            W'($urandom),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 9) < ((i < 400) ? 2 : 8)));
    end
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    drain();

    // reset with 5 words stored and 2 lanes packed
    for (int i = 0; i < 42; i++) cycle(1'b0, 1'b1, W'($urandom), 1'b0, 1'b0);
    check_i("pre_rst_words", int'(bus.rd_water_level), 5);
    cycle(1'b1, 1'b1, 16'hdead, 1'b1, 1'b1);
    check_w("mid_rst_rd_data", bus.rd_data, '0);
    check_i("mid_rst_rd_lanes", int'(bus.rd_lanes), 0);
    check_i("mid_rst_wl", int'(bus.wr_water_level), 0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, W'(16'h0100 + i), 1'b0, 1'b0);
    drain();
    idle();
    check_i("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
